adc_channel_monitor: RTL and testbench

Parametrised successor to the single-channel, free-running ADC front end of controller_top. Time-multiplexes NUM_CH analog channels through one parallel offset-binary ADC via the ADC_MUX select and discards samples while the mux settles. Produces per-channel signed block averages, latched over-level faults with hysteresis, and zero-crossing detection on channel 0. Feeds the gate-timing and protection logic.

---
 rtl/adc_mon_pkg.sv | 31 +++
 rtl/adc_hyst_cmp.sv | 59 +++++
 rtl/adc_channel_monitor.sv | 152 +++++++++++++++
 tb/tb_adc_channel_monitor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_mon_pkg.sv
// Shared types and elaboration helpers for the multiplexed ADC channel monitor.
package adc_mon_pkg;

    typedef enum logic {
        SETTLING = 1'b0,
        ACCUM    = 1'b1
    } mon_state_t;

    typedef enum logic [1:0] {
        ZC_UNKNOWN = 2'd0,
        ZC_POS     = 2'd1,
        ZC_NEG     = 2'd2
    } zc_region_t;

    localparam int SETTLE_W = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Midscale code of an offset-binary converter of the given width.
    function automatic int sample_offset(input int data_w);
        return 1 << (data_w - 1);
    endfunction

endpackage

// File: rtl/adc_hyst_cmp.sv
// Per-channel magnitude compare with hysteresis and a latched fault bit,
// evaluated once per new block average.
module adc_hyst_cmp
    import adc_mon_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] avg,
    input  logic                     avg_valid,
    input  logic [DATA_W-2:0]        trip_level,
    input  logic [DATA_W-2:0]        hyst,
    input  logic                     fault_clr,
    output logic                     over_level,
    output logic                     fault
);

    localparam int MAG_W = DATA_W - 1;

    // |v| in MAG_W bits; the most-negative code clamps to full scale.
    function automatic logic [MAG_W-1:0] sat_mag(input logic signed [DATA_W-1:0] v);
        if (v[DATA_W-1] && (v[DATA_W-2:0] == '0)) return '1;
        if (v[DATA_W-1]) return MAG_W'(-v);
        return MAG_W'(v);
    endfunction

    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] release_lvl;
    logic             set_hit;
    logic             clr_hit;
    logic             level_nxt;
    logic             level_rise;

    always_comb begin
        mag         = sat_mag(avg);
        release_lvl = trip_level - hyst;
        set_hit     = (mag >= trip_level);
        clr_hit     = (hyst > trip_level) ? (mag == '0) : (mag < release_lvl);
        level_nxt   = over_level;
        if (avg_valid) begin
            if (set_hit)      level_nxt = 1'b1;
            else if (clr_hit) level_nxt = 1'b0;
        end
        level_rise = level_nxt & ~over_level;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            over_level <= 1'b0;
            fault      <= 1'b0;
        end else begin
            over_level <= level_nxt;
            if (level_rise)     fault <= 1'b1;
            else if (fault_clr) fault <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_channel_monitor.sv
// Time-multiplexed ADC front end: mux sequencing with settle discard, per-channel
// block averages, over-level hysteresis/fault slices and channel-0 zero-cross detect.
module adc_channel_monitor
    import adc_mon_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int NUM_CH      = 2,
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE      = 3,
    parameter int ZC_DEADBAND = 8,
    localparam int CH_W       = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        adc_data,
    input  logic                     sample_en,
    output logic [CH_W-1:0]          adc_mux,
    input  logic [DATA_W-2:0]        trip_level,
    input  logic [DATA_W-2:0]        hyst,
    input  logic                     fault_clr,
    output logic [NUM_CH*DATA_W-1:0] avg_data,
    output logic [NUM_CH-1:0]        avg_valid,
    output logic [NUM_CH-1:0]        fault,
    output logic [NUM_CH-1:0]        over_level,
    output logic                     zc_pulse,
    output logic                     zc_dir
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [DATA_W-1:0]        OFFSET      = DATA_W'(sample_offset(DATA_W));
    localparam logic [CNT_W-1:0]         LAST_IDX    = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0]          LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [SETTLE_W-1:0]      SETTLE_INIT = SETTLE_W'(SETTLE);
    localparam logic signed [DATA_W-1:0] DB_POS      = DATA_W'(ZC_DEADBAND);

    // Block average, truncating toward -inf.
    function automatic logic signed [DATA_W-1:0] trunc_avg(input logic signed [ACC_W-1:0] sum);
        return DATA_W'(sum >>> AVG_LOG2);
    endfunction

    mon_state_t                 state, state_nxt;
    zc_region_t                 zc_region, zc_region_nxt, zc_seen;
    logic [SETTLE_W-1:0]        settle_cnt, settle_nxt;
    logic [CNT_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc, acc_sum;
    logic signed [DATA_W-1:0]   s_p0;
    logic signed [DATA_W-1:0]   avg_new;
    logic                       take, visit_done;
    logic                       zc_fire, zc_dir_nxt;
    logic [NUM_CH*DATA_W-1:0]   avg_p1;
    logic [NUM_CH-1:0]          vld_p1;

    // Stage p0: offset-binary to two's complement.
    assign s_p0    = $signed(adc_data - OFFSET);
    assign acc_sum = acc + ACC_W'(s_p0);
    assign avg_new = trunc_avg(acc_sum);

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        take       = 1'b0;
        visit_done = 1'b0;
        if (sample_en) begin
            case (state)
                SETTLING: begin
                    if (settle_cnt != '0) settle_nxt = settle_cnt - SETTLE_W'(1);
                    else                  take       = 1'b1;
                end
                ACCUM:   take = 1'b1;
                default: take = 1'b0;
            endcase
            if (take) begin
                if (idx == LAST_IDX) begin
                    visit_done = 1'b1;
                    state_nxt  = SETTLING;
                    settle_nxt = SETTLE_INIT;
                end else begin
                    state_nxt = ACCUM;
                end
            end
        end
    end

    always_comb begin
        zc_region_nxt = zc_region;
        zc_seen       = ZC_UNKNOWN;
        zc_fire       = 1'b0;
        zc_dir_nxt    = 1'b0;
        if (sample_en && (adc_mux == '0) && ((s_p0 > DB_POS) || (s_p0 < -DB_POS))) begin
            zc_seen       = (s_p0 > DB_POS) ? ZC_POS : ZC_NEG;
            zc_fire       = (zc_region != ZC_UNKNOWN) && (zc_region != zc_seen);
            zc_dir_nxt    = (zc_seen == ZC_POS);
            zc_region_nxt = zc_seen;
        end
        // Returning to channel 0 after other channels: history is stale.
        if (visit_done && (NUM_CH > 1) && (adc_mux == LAST_CH)) zc_region_nxt = ZC_UNKNOWN;
    end

    // Stage p1: registered averages, strobes and zero-cross pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SETTLING;
            settle_cnt <= SETTLE_INIT;
            idx        <= '0;
            acc        <= '0;
            adc_mux    <= '0;
            avg_p1     <= '0;
            vld_p1     <= '0;
            zc_region  <= ZC_UNKNOWN;
            zc_pulse   <= 1'b0;
            zc_dir     <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            vld_p1     <= '0;
            zc_region  <= zc_region_nxt;
            zc_pulse   <= zc_fire;
            if (zc_fire) zc_dir <= zc_dir_nxt;
            if (take) begin
                if (visit_done) begin
                    acc                               <= '0;
                    idx                               <= '0;
                    avg_p1[adc_mux*DATA_W +: DATA_W]  <= avg_new;
                    vld_p1[adc_mux]                   <= 1'b1;
                    adc_mux <= (adc_mux == LAST_CH) ? '0 : adc_mux + CH_W'(1);
                end else begin
                    acc <= acc_sum;
                    idx <= idx + CNT_W'(1);
                end
            end
        end
    end

    assign avg_data  = avg_p1;
    assign avg_valid = vld_p1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        adc_hyst_cmp #(.DATA_W(DATA_W)) u_cmp (
            .clk        (clk),
            .rst_n      (rst_n),
            .avg        (avg_p1[i*DATA_W +: DATA_W]),
            .avg_valid  (vld_p1[i]),
            .trip_level (trip_level),
            .hyst       (hyst),
            .fault_clr  (fault_clr),
            .over_level (over_level[i]),
            .fault      (fault[i])
        );
    end

endmodule

// File: tb/tb_adc_channel_monitor.sv
// Scoreboard bench: stimulus feeds a visit-level reference model that queues
// expected averages/levels/crossings; a monitor pops them when the DUT strobes.
module tb_adc_channel_monitor;

    localparam int DATA_W = 10;
    localparam int NUM_CH = 2;
    localparam int AVG_LOG2 = 2;
    localparam int SETTLE = 3;
    localparam int DB = 8;
    localparam int NAVG = 1 << AVG_LOG2;
    localparam int MID = 512;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [DATA_W-1:0]        adc_data;
    logic                     sample_en;
    logic [0:0]               adc_mux;
    logic [DATA_W-2:0]        trip_level;
    logic [DATA_W-2:0]        hyst;
    logic                     fault_clr;
    logic [NUM_CH*DATA_W-1:0] avg_data;
    logic [NUM_CH-1:0]        avg_valid;
    logic [NUM_CH-1:0]        fault;
    logic [NUM_CH-1:0]        over_level;
    logic                     zc_pulse;
    logic                     zc_dir;

    adc_channel_monitor #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2),
        .SETTLE(SETTLE), .ZC_DEADBAND(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .sample_en(sample_en),
        .adc_mux(adc_mux), .trip_level(trip_level), .hyst(hyst), .fault_clr(fault_clr),
        .avg_data(avg_data), .avg_valid(avg_valid), .fault(fault),
        .over_level(over_level), .zc_pulse(zc_pulse), .zc_dir(zc_dir)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int ch; int avg; bit lvl; bit flt; int cyc; } avg_item_t;
    typedef struct { bit dir; int cyc; } zc_item_t;
    avg_item_t avg_q[$];
    zc_item_t  zc_q[$];

    int n_checks = 0;
    int n_err = 0;

    // Reference model state: position within the current visit, not an FSM.
    int m_ch, m_pos, m_sum, m_reg;   // m_reg: 0 unknown, 1 positive, 2 negative
    bit m_lvl[NUM_CH];
    bit m_flt[NUM_CH];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int flt_bits();
        int v;
        v = 0;
        for (int i = 0; i < NUM_CH; i++) if (m_flt[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_reset();
        m_ch = 0; m_pos = 0; m_sum = 0; m_reg = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_lvl[i] = 1'b0;
            m_flt[i] = 1'b0;
        end
    endtask

    task automatic model_sample(input int d);
        int s, a, mag, trip, hy;
        bit lv, pos;
        s = d - MID;
        if (m_ch == 0 && (s > DB || s < -DB)) begin
            pos = (s > 0);
            if (m_reg != 0 && ((m_reg == 1) != pos)) zc_q.push_back('{dir: pos, cyc: cyc + 1});
            m_reg = pos ? 1 : 2;
        end
        if (m_pos >= SETTLE) m_sum += s;
        if (m_pos == SETTLE + NAVG - 1) begin
            a = floor_div(m_sum, NAVG);
            mag = (a < 0) ? -a : a;
            if (mag > MID - 1) mag = MID - 1;
            trip = int'(trip_level);
            hy = int'(hyst);
            lv = m_lvl[m_ch];
            if (mag >= trip) lv = 1'b1;
            else if ((hy > trip) ? (mag == 0) : (mag < trip - hy)) lv = 1'b0;
            if (lv && !m_lvl[m_ch]) m_flt[m_ch] = 1'b1;
            m_lvl[m_ch] = lv;
            avg_q.push_back('{ch: m_ch, avg: a, lvl: lv, flt: m_flt[m_ch], cyc: cyc + 1});
            m_pos = 0;
            m_sum = 0;
            m_ch = (m_ch + 1) % NUM_CH;
            if (NUM_CH > 1 && m_ch == 0) m_reg = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic step(input bit en, input int d, input bit clr = 1'b0);
        check("adc_mux", int'(adc_mux), m_ch);
        sample_en = en;
        adc_data = DATA_W'(d);
        fault_clr = clr;
        if (en) model_sample(d);
        if (clr) for (int i = 0; i < NUM_CH; i++) m_flt[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, MID);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sample_en = 1'b0;
        fault_clr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_adc_mux", int'(adc_mux), 0);
        check("rst_avg_data", int'(avg_data), 0);
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_over_level", int'(over_level), 0);
        check("rst_zc_pulse", int'(zc_pulse), 0);
        check("rst_zc_dir", int'(zc_dir), 0);
        check("rst_avg_pending", avg_q.size(), 0);
        avg_q.delete();
        zc_q.delete();
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT strobes an output.
    initial begin
        avg_item_t it;
        zc_item_t  zi;
        bit pend;
        int pch;
        bit plvl, pflt;
        logic signed [DATA_W-1:0] got;
        pend = 1'b0;
        pch = 0; plvl = 1'b0; pflt = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check($sformatf("over_level_ch%0d", pch), int'(over_level[pch]), int'(plvl));
                check($sformatf("fault_ch%0d", pch), int'(fault[pch]), int'(pflt));
                pend = 1'b0;
            end
            if (avg_valid != '0) begin
                if (avg_q.size() == 0) begin
                    check("avg_valid_unexpected", int'(avg_valid), 0);
                end else begin
                    it = avg_q.pop_front();
                    got = avg_data[it.ch*DATA_W +: DATA_W];
                    check("avg_valid_ch", int'(avg_valid), 1 << it.ch);
                    check($sformatf("avg_ch%0d", it.ch), int'(got), it.avg);
                    check("avg_latency", cyc, it.cyc);
                    pend = 1'b1;
                    pch = it.ch; plvl = it.lvl; pflt = it.flt;
                end
            end
            if (zc_pulse) begin
                if (zc_q.size() == 0) begin
                    check("zc_pulse_unexpected", 1, 0);
                end else begin
                    zi = zc_q.pop_front();
                    check("zc_dir", int'(zc_dir), int'(zi.dir));
                    check("zc_latency", cyc, zi.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int zpat[10] = '{612, 516, 508, 412, 509, 515, 612, 412, 520, 600};
        int k, d;
        rst_n = 1'b0;
        sample_en = 1'b0;
        adc_data = DATA_W'(MID);
        fault_clr = 1'b0;
        trip_level = 9'd511;
        hyst = 9'd0;
        model_reset();
        do_reset(2);

        // Constant +300 on both channels, then a step to +450.
        repeat (30) step(1'b1, 812);
        repeat (30) step(1'b1, 962);

        // Hysteresis: 450 sets, 380 holds, 340 releases; fault latches.
        idle(3);
        trip_level = 9'd400;
        hyst = 9'd50;
        repeat (28) step(1'b1, 962);
        repeat (28) step(1'b1, 892);
        repeat (28) step(1'b1, 852);
        idle(3);
        step(1'b0, MID, 1'b1);
        check("fault_after_clr", int'(fault), flt_bits());
        repeat (28) step(1'b1, 962);
        idle(3);
        step(1'b0, MID, 1'b1);
        check("fault_clr_while_over", int'(fault), flt_bits());
        repeat (28) step(1'b1, 962);

        // Most-negative average saturates to full-scale magnitude.
        idle(3);
        trip_level = 9'd511;
        hyst = 9'd0;
        repeat (28) step(1'b1, MID);
        idle(3);
        step(1'b0, MID, 1'b1);
        check("fault_cleared_pre_sat", int'(fault), flt_bits());
        repeat (28) step(1'b1, 0);

        // Zero-crossing pattern on channel 0 with in-band samples mixed in.
        idle(3);
        k = 0;
        repeat (90) begin
            if (m_ch == 0) begin
                d = zpat[k % 10];
                k++;
            end else begin
                d = int'($urandom_range(0, 1023));
            end
            step(1'b1, d);
        end

        // Randomized traffic with gaps.
        idle(3);
        trip_level = 9'($urandom_range(60, 300));
        hyst = 9'($urandom_range(0, 150));
        repeat (800) begin
            if ($urandom_range(0, 3) == 0) d = MID - 20 + int'($urandom_range(0, 40));
            else if ($urandom_range(0, 1) == 0) d = MID + int'($urandom_range(0, 350));
            else d = int'($urandom_range(0, 1023));
            step($urandom_range(0, 3) != 0, d);
        end

        // Reset partway into an accumulation; the next average must be clean.
        idle(3);
        for (int g = 0; g < 20 && m_pos != SETTLE + 1; g++) step(1'b1, 100);
        idle(3);
        do_reset(1);
        repeat (30) step(1'b1, 700);

        idle(6);
        check("avg_queue_drained", avg_q.size(), 0);
        check("zc_queue_drained", zc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
